// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction-memory controller.
package inst_mem_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Width of the wait-state counter (holds WAIT_STATES up to 15)
    localparam int CNT_W = 4;

    // Word returned for fetches that fall outside the RAM window
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // An offset lies inside the window when no bit at or above abits is set.
    // Offsets below the base wrap to large values and fall out naturally.
    function automatic logic in_window(input logic [29:0] offset, input int abits);
        logic [29:0] upper;
        upper = offset >> abits;
        return (upper == 30'd0);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port word RAM: synchronous write, one-cycle synchronous read,
// write takes priority over read when both are requested.
module imem_ram
    import inst_mem_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Array write; contents survive reset so a preloaded program is kept
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port, suppressed when a write uses the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= NOP_WORD;
        end else if (re && !we) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction-memory slave: accepts a fetch, waits a programmable number of
// cycles, reads the backing RAM and returns the word with a one-cycle ack.
// Addresses outside the RAM window return a NOP and flag Bus_Error.
module inst_mem_ctrl
    import inst_mem_pkg::*;
#(
    parameter int          ADDR_BITS   = 10,
    parameter logic [29:0] BASE_ADDR   = 30'h0000_0FF8,
    parameter int          WAIT_STATES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [29:0]          InstMem_Address,
    input  logic                 InstMem_Read,
    output logic [31:0]          InstMem_In,
    output logic                 InstMem_Ack,
    input  logic                 Load_En,
    input  logic [ADDR_BITS-1:0] Load_Addr,
    input  logic [31:0]          Load_Data,
    output logic                 Bus_Error,
    output logic                 Busy
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [ADDR_BITS-1:0]   idx_r;
    logic                   in_range_r;
    logic                   ack_r;
    logic                   berr_r;
    logic                   busy_r;
    logic [31:0]            data_r;

    logic [29:0]            offset_s;
    logic                   issue_slot_s;
    logic                   read_issue_s;
    logic                   hold_s;
    logic [ADDR_BITS-1:0]   ram_addr_s;
    logic [31:0]            ram_rdata_s;

    // Window offset, read-issue decision and RAM port address selection.
    // A preload in the issue slot owns the single RAM port, so the read
    // slips by one cycle instead of racing the write.
    always_comb begin
        offset_s     = InstMem_Address - BASE_ADDR;
        issue_slot_s = 1'b0;
        read_issue_s = 1'b0;
        hold_s       = 1'b0;
        if ((state_r == ST_WAIT) && InstMem_Read && (cnt_r <= 4'd1) && in_range_r) begin
            issue_slot_s = 1'b1;
            read_issue_s = !Load_En;
            hold_s       = Load_En;
        end else begin
            issue_slot_s = 1'b0;
            read_issue_s = 1'b0;
            hold_s       = 1'b0;
        end
        if (Load_En) begin
            ram_addr_s = Load_Addr;
        end else begin
            ram_addr_s = idx_r;
        end
    end

    imem_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clock),
        .rst_n (reset),
        .we    (Load_En),
        .re    (read_issue_s),
        .addr  (ram_addr_s),
        .wdata (Load_Data),
        .rdata (ram_rdata_s)
    );

    // Fetch sequencing FSM with registered response outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            idx_r      <= '0;
            in_range_r <= 1'b0;
            ack_r      <= 1'b0;
            berr_r     <= 1'b0;
            busy_r     <= 1'b0;
            data_r     <= NOP_WORD;
        end else begin
            ack_r  <= 1'b0;
            berr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (InstMem_Read) begin
                        idx_r      <= offset_s[ADDR_BITS-1:0];
                        in_range_r <= in_window(offset_s, ADDR_BITS);
                        cnt_r      <= WAIT_LOAD;
                        state_r    <= ST_WAIT;
                        busy_r     <= 1'b1;
                    end else begin
                        busy_r     <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!InstMem_Read) begin
                        // Core flushed the fetch: drop it silently
                        cnt_r   <= 4'd0;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (cnt_r <= 4'd1) begin
                        if (hold_s) begin
                            cnt_r <= 4'd1;
                        end else begin
                            cnt_r   <= 4'd0;
                            state_r <= ST_RESP;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    ack_r   <= 1'b1;
                    berr_r  <= !in_range_r;
                    data_r  <= in_range_r ? ram_rdata_s : NOP_WORD;
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    cnt_r   <= 4'd0;
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign InstMem_In  = data_r;
    assign InstMem_Ack = ack_r;
    assign Bus_Error   = berr_r;
    assign Busy        = busy_r;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Scoreboard bench for inst_mem_ctrl: one instance with one wait state and
// one with four wait states share the request and preload inputs.
module tb_inst_mem_ctrl;

    localparam logic [29:0] BASE  = 30'h0000_0FF8;
    localparam int          DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic [29:0] addr;
    logic        rd;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    logic [31:0] in1, in4;
    logic        ack1, ack4, berr1, berr4, busy1, busy4;

    int tests = 0;
    int fails = 0;
    int ack_count1 = 0;

    typedef struct {
        logic [31:0] data;
        logic        berr;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    inst_mem_ctrl #(.ADDR_BITS(10), .BASE_ADDR(BASE), .WAIT_STATES(1)) dut1 (
        .clock(clock), .reset(reset), .InstMem_Address(addr), .InstMem_Read(rd),
        .InstMem_In(in1), .InstMem_Ack(ack1), .Load_En(load_en), .Load_Addr(load_addr),
        .Load_Data(load_data), .Bus_Error(berr1), .Busy(busy1));

    inst_mem_ctrl #(.ADDR_BITS(10), .BASE_ADDR(BASE), .WAIT_STATES(4)) dut4 (
        .clock(clock), .reset(reset), .InstMem_Address(addr), .InstMem_Read(rd),
        .InstMem_In(in4), .InstMem_Ack(ack4), .Load_En(load_en), .Load_Addr(load_addr),
        .Load_Data(load_data), .Bus_Error(berr4), .Busy(busy4));

    // Count every ack from the one-wait-state instance
    always @(posedge clock) begin
        if (ack1 === 1'b1) ack_count1 <= ack_count1 + 1;
    end

    // Wait (bounded) for the next ack of the selected instance
    task automatic wait_ack(input bit sel4, input int budget, output bit seen,
                            output int cycles, output logic [31:0] data, output logic berr);
        seen = 1'b0; cycles = 0; data = 32'h0; berr = 1'b0;
        while (!seen && cycles < budget) begin
            @(negedge clock);
            cycles++;
            if ((sel4 ? ack4 : ack1) === 1'b1) begin
                seen = 1'b1;
                data = sel4 ? in4 : in1;
                berr = sel4 ? berr4 : berr1;
            end
        end
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d);
        @(negedge clock);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clock);
        load_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; rd = 1'b0; addr = 30'h0; load_en = 1'b0; load_addr = 10'h0; load_data = 32'h0;
        repeat (2) @(negedge clock);
        tests++;
        if ({ack1, berr1, busy1, in1} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_state: ack=%b berr=%b busy=%b in=%h, required 0 0 0 00000000", ack1, berr1, busy1, in1);
        end
        reset = 1'b1;
        load_word(10'd0, 32'h20130003);
        load_word(10'd1, 32'h20110001);
        load_word(10'd2, 32'h0291A022);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single;
        bit seen; int cyc; logic [31:0] d; logic b; exp_t e;
        sb.push_back('{32'h20130003, 1'b0});
        addr = BASE; rd = 1'b1;
        wait_ack(1'b0, 20, seen, cyc, d, b);
        rd = 1'b0;
        e = sb.pop_front();
        tests++;
        if (!seen || cyc !== 3) begin
            fails++; $display("FAIL single_latency: seen=%b cycles=%0d, required ack at cycle 3", seen, cyc);
        end
        tests++;
        if (d !== e.data || b !== e.berr) begin
            fails++; $display("FAIL single_data: data=%h berr=%b, required %h %b", d, b, e.data, e.berr);
        end
        @(negedge clock);
        tests++;
        if (ack1 !== 1'b0 || in1 !== 32'h20130003) begin
            fails++; $display("FAIL single_hold: ack=%b in=%h, required 0 20130003", ack1, in1);
        end
        repeat (8) @(negedge clock);
    endtask

    task automatic test_back_to_back(input bit sel4, input int ws);
        bit seen; int cyc; logic [31:0] d; logic b; exp_t e;
        logic [31:0] words [3];
        words[0] = 32'h20130003; words[1] = 32'h20110001; words[2] = 32'h0291A022;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{words[i], 1'b0});
            addr = BASE + 30'(i); rd = 1'b1;
            wait_ack(sel4, 40, seen, cyc, d, b);
            e = sb.pop_front();
            tests++;
            if (!seen || cyc !== ws + 2) begin
                fails++; $display("FAIL b2b_spacing ws=%0d #%0d: seen=%b cycles=%0d, required %0d", ws, i, seen, cyc, ws + 2);
            end
            tests++;
            if (d !== e.data || b !== e.berr) begin
                fails++; $display("FAIL b2b_data ws=%0d #%0d: data=%h berr=%b, required %h %b", ws, i, d, b, e.data, e.berr);
            end
        end
        rd = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_out_of_range;
        bit seen; int cyc; logic [31:0] d; logic b; exp_t e;
        logic [29:0] bad [2];
        bad[0] = BASE - 30'd1; bad[1] = BASE + 30'(DEPTH);
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{32'h0, 1'b1});
            addr = bad[i]; rd = 1'b1;
            wait_ack(1'b0, 20, seen, cyc, d, b);
            rd = 1'b0;
            e = sb.pop_front();
            tests++;
            if (!seen || d !== e.data || b !== e.berr) begin
                fails++; $display("FAIL oor_resp %h: seen=%b data=%h berr=%b, required 1 %h %b", bad[i], seen, d, b, e.data, e.berr);
            end
            @(negedge clock);
            tests++;
            if (berr1 !== 1'b0) begin
                fails++; $display("FAIL oor_pulse %h: berr=%b one cycle later, required 0", bad[i], berr1);
            end
            repeat (3) @(negedge clock);
        end
        sb.push_back('{32'h20130003, 1'b0});
        addr = BASE; rd = 1'b1;
        wait_ack(1'b0, 20, seen, cyc, d, b);
        rd = 1'b0;
        e = sb.pop_front();
        tests++;
        if (!seen || d !== e.data || b !== e.berr) begin
            fails++; $display("FAIL oor_ram_intact: seen=%b data=%h berr=%b, required 1 %h %b", seen, d, b, e.data, e.berr);
        end
        repeat (8) @(negedge clock);
    endtask

    task automatic test_abort;
        bit seen; int cyc; logic [31:0] d; logic b; exp_t e; int snap;
        snap = ack_count1;
        addr = BASE + 30'd2; rd = 1'b1;
        @(negedge clock);
        tests++;
        if (busy1 !== 1'b1) begin
            fails++; $display("FAIL abort_busy_wait: busy=%b, required 1", busy1);
        end
        rd = 1'b0;
        @(negedge clock);
        tests++;
        if (busy1 !== 1'b0) begin
            fails++; $display("FAIL abort_busy_fall: busy=%b, required 0", busy1);
        end
        repeat (5) @(negedge clock);
        tests++;
        if (ack_count1 !== snap) begin
            fails++; $display("FAIL abort_no_ack: acks=%0d, required %0d", ack_count1, snap);
        end
        sb.push_back('{32'h0291A022, 1'b0});
        rd = 1'b1;
        wait_ack(1'b0, 20, seen, cyc, d, b);
        rd = 1'b0;
        e = sb.pop_front();
        tests++;
        if (!seen || cyc !== 3 || d !== e.data || b !== e.berr) begin
            fails++; $display("FAIL abort_next: seen=%b cycles=%0d data=%h berr=%b, required 1 3 %h %b", seen, cyc, d, b, e.data, e.berr);
        end
        repeat (8) @(negedge clock);
    endtask

    task automatic test_load_collision;
        bit seen; int cyc; logic [31:0] d; logic b; exp_t e;
        sb.push_back('{32'hDEADBEEF, 1'b0});
        addr = BASE + 30'd1; rd = 1'b1;
        @(negedge clock);
        load_en = 1'b1; load_addr = 10'd1; load_data = 32'hDEADBEEF;
        @(negedge clock);
        load_en = 1'b0;
        tests++;
        if (ack1 !== 1'b0) begin
            fails++; $display("FAIL collide_early_ack: ack=%b at cycle 2, required 0", ack1);
        end
        wait_ack(1'b0, 20, seen, cyc, d, b);
        rd = 1'b0;
        e = sb.pop_front();
        tests++;
        if (!seen || cyc + 2 !== 4) begin
            fails++; $display("FAIL collide_latency: seen=%b cycles=%0d, required 4", seen, cyc + 2);
        end
        tests++;
        if (d !== e.data || b !== e.berr) begin
            fails++; $display("FAIL collide_data: data=%h berr=%b, required %h %b", d, b, e.data, e.berr);
        end
        repeat (8) @(negedge clock);
    endtask

    task automatic test_reset_mid_wait;
        bit seen; int cyc; logic [31:0] d; logic b; exp_t e; int snap;
        addr = BASE + 30'd1; rd = 1'b1;
        @(negedge clock);
        snap = ack_count1;
        reset = 1'b0; rd = 1'b0;
        #1;
        tests++;
        if ({ack1, berr1, busy1, in1} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
            fails++; $display("FAIL reset_async: ack=%b berr=%b busy=%b in=%h, required 0 0 0 00000000", ack1, berr1, busy1, in1);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        tests++;
        if (ack_count1 !== snap) begin
            fails++; $display("FAIL reset_discard: acks=%0d, required %0d", ack_count1, snap);
        end
        sb.push_back('{32'h20130003, 1'b0});
        addr = BASE; rd = 1'b1;
        wait_ack(1'b0, 20, seen, cyc, d, b);
        rd = 1'b0;
        e = sb.pop_front();
        tests++;
        if (!seen || d !== e.data || b !== e.berr) begin
            fails++; $display("FAIL reset_ram_kept: seen=%b data=%h berr=%b, required 1 %h %b", seen, d, b, e.data, e.berr);
        end
        repeat (4) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back(1'b0, 1);
        test_back_to_back(1'b1, 4);
        test_out_of_range();
        test_abort();
        test_load_collision();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
